dm_port_arbiter: RTL and testbench

//  Shares the single-port word data memory between two requesters: m0 (pipeline
//  MEM stage) and m1 (loader/debug port). Issues at most one access per cycle,

---
 rtl/dm_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares one single-port word data memory between two requesters:
//   m0 (pipeline MEM stage) and m1 (loader/debug port). At most one access
//   is issued per cycle, and the two requesters take turns (round-robin) when
//   they collide. The block can also run a clear sweep that writes zero to
//   every word of the memory, one word per cycle.
//
// Parameters
//   AW        word-index width; the memory holds DEPTH = 2**AW words
//   W         data width
//
// Ports
//   clk                 clock, rising edge
//   clr_n               asynchronous reset, active low
//   mX_req              access request, held by the requester until mX_gnt
//   mX_we               1 = write, 0 = read
//   mX_addr             byte address (passed to the memory unmodified)
//   mX_wd               write data
//   mX_gnt              access issued this cycle (combinational)
//   mX_rvalid           read data valid, one cycle after a granted read
//   mX_rdata            read data, held until the next read by that master
//   clr_req             start a clear sweep (level sampled in ARB)
//   clr_busy            clear sweep in progress
//   dm_we/dm_addr/dm_wd memory write enable / byte address / write data
//   dm_rd               memory read data (combinational from dm_addr)
module dm_port_arbiter #(
  parameter int unsigned AW = 10,
  parameter int unsigned W  = 32
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [31:0]   m0_addr,
  input  logic [W-1:0]  m0_wd,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [W-1:0]  m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [31:0]   m1_addr,
  input  logic [W-1:0]  m1_wd,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [W-1:0]  m1_rdata,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          dm_we,
  output logic [31:0]   dm_addr,
  output logic [W-1:0]  dm_wd,
  input  logic [W-1:0]  dm_rd
);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] CNT_LAST = '1;

  state_t          state_q, state_d;
  logic            rr_ptr_q, rr_ptr_d;   // 0: m0 preferred on conflict, 1: m1
  logic [AW-1:0]   cnt_q, cnt_d;         // clear-sweep word index
  logic            arb_open;
  logic [31:0]     clr_addr;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= ST_ARB;
      rr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_ARB: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
        end else if (m0_gnt) begin
          rr_ptr_d = 1'b1;
        end else if (m1_gnt) begin
          rr_ptr_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_ARB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: grants and memory-port mux
  // ---------------------------------------------------------------------------
  // Grants are qualified with clr_n so the memory port goes quiet the moment
  // reset asserts, even though the request inputs may still be high.
  assign arb_open = clr_n && (state_q == ST_ARB) && !clr_req;

  always_comb begin
    clr_addr           = '0;
    clr_addr[AW+1:2]   = cnt_q;

    m0_gnt   = arb_open && m0_req && (!m1_req || !rr_ptr_q);
    m1_gnt   = arb_open && m1_req && (!m0_req ||  rr_ptr_q);
    clr_busy = (state_q == ST_CLEAR);

    dm_we   = 1'b0;
    dm_addr = '0;
    dm_wd   = '0;
    if (clr_busy) begin
      dm_we   = 1'b1;
      dm_addr = clr_addr;
    end else if (m0_gnt) begin
      dm_we   = m0_we;
      dm_addr = m0_addr;
      dm_wd   = m0_wd;
    end else if (m1_gnt) begin
      dm_we   = m1_we;
      dm_addr = m1_addr;
      dm_wd   = m1_wd;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path: one-cycle latency, data held until the next read
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt && !m0_we;
      m1_rvalid <= m1_gnt && !m1_we;
      if (m0_gnt && !m0_we) m0_rdata <= dm_rd;
      if (m1_gnt && !m1_we) m1_rdata <= dm_rd;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

  localparam int unsigned AW    = 10;
  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [31:0]   m0_addr, m1_addr;
  logic [W-1:0]  m0_wd, m1_wd;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [W-1:0]  m0_rdata, m1_rdata;
  logic          clr_req, clr_busy;
  logic          dm_we;
  logic [31:0]   dm_addr;
  logic [W-1:0]  dm_wd, dm_rd;

  logic [W-1:0]  mem [0:DEPTH-1];

  int n_tests = 0;
  int n_fail  = 0;

  dm_port_arbiter #(.AW(AW), .W(W)) dut (
    .clk(clk), .clr_n(clr_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory: combinational read, write on posedge.
  assign dm_rd = mem[dm_addr[AW+1:2]];
  always @(posedge clk) begin
    if (dm_we) mem[dm_addr[AW+1:2]] <= dm_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
  endtask

  task automatic m0_write(input logic [31:0] a, input logic [31:0] d);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = a; m0_wd = d;
    #1;
    check("wr_gnt", m0_gnt, 1'b1);
    check("wr_dm_addr", dm_addr, a);
    tick();
    m0_req = 1'b0; m0_we = 1'b0;
    #1;
    check("wr_no_rvalid", m0_rvalid, 1'b0);
  endtask

  task automatic do_read(input bit m, input logic [31:0] a, input logic [31:0] exp);
    if (!m) begin m0_req = 1'b1; m0_we = 1'b0; m0_addr = a; end
    else    begin m1_req = 1'b1; m1_we = 1'b0; m1_addr = a; end
    #1;
    check("rd_gnt", m ? m1_gnt : m0_gnt, 1'b1);
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    #1;
    check("rd_rvalid", m ? m1_rvalid : m0_rvalid, 1'b1);
    check("rd_rdata", m ? m1_rdata : m0_rdata, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cycles;
    int bad;
    logic [31:0] last_addr;

    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h5A5A_0000 + i;
    clr_n = 1'b0; clr_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wd = 32'h1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = '0;     m1_wd = '0;
    repeat (2) tick();

    // Reset state: requests are high but nothing may be issued.
    check("rst_m0_gnt", m0_gnt, 1'b0);
    check("rst_m1_gnt", m1_gnt, 1'b0);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    check("rst_busy", clr_busy, 1'b0);
    check("rst_dm_we", dm_we, 1'b0);
    check("rst_dm_addr", dm_addr, 32'h0);
    check("rst_dm_wd", dm_wd, 32'h0);
    check("rst_rdata", m0_rdata, 32'h0);
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0;
    clr_n = 1'b1;
    tick();

    // 1: write then read back with one-cycle latency
    m0_write(32'h0000_3004, 32'hDEAD_BEEF);
    do_read(1'b0, 32'h0000_3004, 32'hDEAD_BEEF);

    // 2: both requesting continuously after reset alternate m0,m1,m0,m1
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_m0_gnt", m0_gnt, (i % 2) == 0);
      check("rr_m1_gnt", m1_gnt, (i % 2) == 1);
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    // 3: fill words 0..3, one-cycle clr_req pulse with m0 read of word 3 pending
    for (int i = 0; i < 4; i++) m0_write(32'(i * 4), 32'h1111_0001 + i);
    clr_req = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'hC;
    #1;
    check("clr_prio_m0_gnt", m0_gnt, 1'b0);
    check("clr_start_busy", clr_busy, 1'b0);
    tick();
    clr_req = 1'b0;
    cycles = 0; bad = 0; last_addr = '1;
    #1;
    while (clr_busy && cycles < 2000) begin
      if (dm_addr !== 32'(cycles * 4) || dm_we !== 1'b1 || dm_wd !== '0 || m0_gnt !== 1'b0)
        bad++;
      last_addr = dm_addr;
      tick();
      cycles++;
    end
    check("sweep_cycles", cycles, DEPTH);
    check("sweep_pattern_errs", bad, 0);
    check("sweep_last_addr", last_addr, 32'hFFC);
    check("post_sweep_m0_gnt", m0_gnt, 1'b1);
    tick();
    m0_req = 1'b0;
    #1;
    check("post_sweep_rvalid", m0_rvalid, 1'b1);
    check("word3_cleared", m0_rdata, 32'h0);

    // 4: clr_req and m1_req rise together; m1 waits for the whole sweep
    clr_req = 1'b1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_wd = 32'hCAFE_0004;
    #1;
    check("t4_m1_gnt_start", m1_gnt, 1'b0);
    tick();
    clr_req = 1'b0;
    cycles = 0; bad = 0;
    #1;
    while (clr_busy && cycles < 2000) begin
      if (m1_gnt !== 1'b0) bad++;
      tick();
      cycles++;
    end
    check("t4_sweep_cycles", cycles, DEPTH);
    check("t4_m1_gnt_in_sweep", bad, 0);
    check("t4_m1_gnt_after", m1_gnt, 1'b1);
    check("t4_dm_wd", dm_wd, 32'hCAFE_0004);
    tick();
    m1_req = 1'b0; m1_we = 1'b0;
    do_read(1'b1, 32'h10, 32'hCAFE_0004);

    // 5: reset at sweep cycle 100 aborts the sweep
    m0_write(32'h18C, 32'h0000_0099);
    m0_write(32'h190, 32'h0000_0100);
    m0_write(32'h320, 32'h0000_0200);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("t5_addr_at_100", dm_addr, 32'h190);
    clr_n = 1'b0;
    #1;
    check("t5_busy_async", clr_busy, 1'b0);
    check("t5_dm_we_async", dm_we, 1'b0);
    tick();
    clr_n = 1'b1;
    tick();
    do_read(1'b0, 32'h18C, 32'h0);
    do_read(1'b0, 32'h190, 32'h0000_0100);
    do_read(1'b0, 32'h320, 32'h0000_0200);

    // 6: m1 read followed by m0 write
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h320;
    #1;
    check("t6_m1_gnt", m1_gnt, 1'b1);
    tick();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wd = 32'h1234_5678;
    #1;
    check("t6_m0_gnt", m0_gnt, 1'b1);
    check("t6_m1_rvalid", m1_rvalid, 1'b1);
    check("t6_m1_rdata", m1_rdata, 32'h0000_0200);
    check("t6_m0_rvalid", m0_rvalid, 1'b0);
    tick();
    m0_req = 1'b0; m0_we = 1'b0;
    #1;
    check("t6_m1_rvalid_drop", m1_rvalid, 1'b0);
    check("t6_m0_rvalid_after_wr", m0_rvalid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
